// File: rtl/riscv_pkg.sv
// Shared core definitions used by the register-file write-port arbiter.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_t;
endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry parking register for a mul/div result waiting for a free write-port slot.
module wb_hold_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [XLEN-1:0]       load_data,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       data
);

  // load and clear are never both asserted: load needs an empty buffer, clear a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= load_rd;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order WB stage and the out-of-order mul/div unit.
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_RegWrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_wdata,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_result,
  output logic                  md_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  bubble_req,
  output logic                  pend_valid,
  output logic [REG_ADDR_W-1:0] pend_rd,
  output wb_arb_state_t         state_dbg
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_t         state;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_inc;
  logic                  buf_valid;
  logic [REG_ADDR_W-1:0] buf_rd;
  logic [XLEN-1:0]       buf_data;
  logic                  wb_wr;
  logic                  accept;
  logic                  load;
  logic                  drain;
  logic                  waw;
  logic                  clear;
  logic                  blocked;

  // Handshake: a mul/div result transfers on any rising edge where md_valid && md_ready;
  // md_ready depends only on registered state, never on md_valid, and a result
  // with md_rd==0 still transfers but is not stored.
  assign md_ready = !buf_valid;
  assign wb_wr    = wb_RegWrite && (wb_rd != '0);
  assign accept   = md_valid && md_ready;
  assign load     = accept && (md_rd != '0);
  assign drain    = buf_valid && !wb_wr;
  assign waw      = buf_valid && wb_wr && (wb_rd == buf_rd);
  assign clear    = drain || waw;
  assign blocked  = buf_valid && wb_wr && !waw;

  assign count_inc = (count == CW'(STARVE_LIMIT)) ? count : count + 1'b1;

  wb_hold_buffer #(.XLEN(XLEN)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .clear     (clear),
    .load_rd   (md_rd),
    .load_data (md_result),
    .valid     (buf_valid),
    .rd        (buf_rd),
    .data      (buf_data)
  );

  // FORCE is entered after STARVE_LIMIT-1 blocked cycles so the bubble request is
  // visible during the STARVE_LIMIT-th blocked cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= (STARVE_LIMIT <= 1) ? FORCE : HELD;
            count <= '0;
          end
        end
        HELD: begin
          if (clear) begin
            state <= EMPTY;
            count <= '0;
          end else if (blocked) begin
            count <= count_inc;
            if (int'(count) + 1 >= STARVE_LIMIT - 1) state <= FORCE;
          end
        end
        FORCE: begin
          if (clear) begin
            state <= EMPTY;
            count <= '0;
          end else if (blocked) begin
            count <= count_inc;
          end
        end
        default: begin
          state <= EMPTY;
          count <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (wb_wr) begin
      rf_we    = 1'b1;
      rf_rd    = wb_rd;
      rf_wdata = wb_wdata;
    end else if (buf_valid) begin
      rf_we    = 1'b1;
      rf_rd    = buf_rd;
      rf_wdata = buf_data;
    end
  end

  assign bubble_req = (state == FORCE);
  assign pend_valid = buf_valid;
  assign pend_rd    = buf_valid ? buf_rd : '0;
  assign state_dbg  = state;

endmodule
